out_port_fifo: RTL

Output-port buffer for the TurtleMCU core: the consumer end of the `OUT` instruction interface. On each single-cycle `output_valid` pulse from the control unit it captures the 16-bit register-file operand into a small FIFO. It drains the FIFO to an external consumer over a valid/ready handshake and reports back-pressure and lost words to the core.

---
 rtl/out_port_fifo_pkg.sv | 8 +
 rtl/out_port_fifo.sv | 101 ++++++++++
 2 files changed

// File: rtl/out_port_fifo_pkg.sv
// Shared constants for the TurtleMCU output-port buffer.
// OUT_FIFO_DEPTH sits alongside the other core-wide sizing constants.
package out_port_fifo_pkg;

    localparam int OUT_FIFO_DEPTH  = 4;
    localparam int OUT_FIFO_DATA_W = 16;

endpackage

// File: rtl/out_port_fifo.sv
// Output-port buffer: captures OUT-instruction operands into a small FIFO and
// drains them to an external consumer, flagging words lost to back-pressure.
module out_port_fifo
    import out_port_fifo_pkg::*;
#(
    parameter  int DATA_W = OUT_FIFO_DATA_W,
    parameter  int DEPTH  = OUT_FIFO_DEPTH,  // power of two, >= 2
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              full,
    output logic              ext_valid,
    output logic [DATA_W-1:0] ext_data,
    input  logic              ext_ready,
    output logic [CW-1:0]     count,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshake: a word moves to the consumer in every cycle where
    // ext_valid && ext_ready at the rising edge; ext_valid/ext_data are
    // registered and hold steady until that happens.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d, rp_nxt;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              ext_valid_q, ext_valid_d;
    logic [DATA_W-1:0] ext_data_q, ext_data_d;
    logic              overflow_q, overflow_d;
    logic              push, pop, drop;

    always_comb begin
        pop         = ext_valid_q & ext_ready;
        push        = cpu_valid & (~full_q | pop);
        drop        = cpu_valid & full_q & ~pop;
        rp_nxt      = rp_q + AW'(1);
        count_d     = count_q;
        wp_d        = push ? wp_q + AW'(1) : wp_q;
        rp_d        = pop ? rp_nxt : rp_q;
        ext_data_d  = ext_data_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Head register tracks the oldest live word; storage only backs it up.
        if (pop) begin
            if (count_q > CW'(1))
                ext_data_d = mem_q[rp_nxt];
            else if (push)
                ext_data_d = cpu_data;
        end else if (push && (count_q == '0)) begin
            ext_data_d = cpu_data;
        end

        ext_valid_d = (count_d != '0);
        full_d      = (count_d == DEPTH_C);
        overflow_d  = drop | (overflow_q & ~clr_overflow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            ext_valid_q <= 1'b0;
            ext_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            full_q      <= full_d;
            ext_valid_q <= ext_valid_d;
            ext_data_q  <= ext_data_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wp_q] <= cpu_data;
    end

    assign full      = full_q;
    assign ext_valid = ext_valid_q;
    assign ext_data  = ext_data_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule
